mux_test_sequencer: RTL

- Stimulus-and-check stage that sits directly upstream of the 2:1 mux debug block.
- Drives the mux select/data inputs S, I0, I1 through all 8 combinations.
- Samples the 9-bit debug vector returned by the mux and compares it against the fixed debug-vector contract.
- Reports pass/fail, an error count and the first failing vector; this is the on-board self-test for the mux stage.

---
 rtl/mux_test_pkg.sv | 27 ++
 rtl/mux_expected_gen.sv | 14 +
 rtl/mux_test_sequencer.sv | 120 ++++++++++++
 3 files changed

// File: rtl/mux_test_pkg.sv
// Shared definitions for the mux self-test sequencer: FSM encoding,
// vector count and the debug-vector contract of the 2:1 mux stage.
package mux_test_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_CHECK  = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    localparam int unsigned NUM_VECTORS = 8;
    localparam int unsigned IDX_W       = 3;
    localparam int unsigned DBG_W       = 9;

    // Expected debug vector for stimulus {S,I0,I1} = idx.
    function automatic logic [DBG_W-1:0] expected_vec(input logic [IDX_W-1:0] idx);
        logic s_v;
        logic i0_v;
        logic i1_v;
        s_v  = idx[2];
        i0_v = idx[1];
        i1_v = idx[0];
        return {1'b1, (i0_v & ~s_v), 1'b1, ~s_v, s_v, s_v, s_v, i1_v, i0_v};
    endfunction

endpackage

// File: rtl/mux_expected_gen.sv
// Combinational expected-vector generator for the mux debug contract.
module mux_expected_gen
    import mux_test_pkg::*;
(
    input  logic [IDX_W-1:0] idx,
    output logic [DBG_W-1:0] expected
);

    // Map the applied stimulus index to the debug vector the mux must return.
    always_comb begin
        expected = expected_vec(idx);
    end

endmodule

// File: rtl/mux_test_sequencer.sv
// On-board self-test for the 2:1 mux debug stage: walks all eight
// {S,I0,I1} combinations, checks the returned debug vector and reports
// pass/fail, a saturating error count and the first failing vector.
module mux_test_sequencer
    import mux_test_pkg::*;
#(
    parameter int HOLD_CYCLES = 2,
    parameter int ERR_W       = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [8:0]       mux_out,
    output logic             S,
    output logic             I0,
    output logic             I1,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic [2:0]       vec_idx,
    output logic [2:0]       first_fail_idx,
    output logic [8:0]       first_fail_mask
);

    localparam int              HC_W        = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [HC_W-1:0] HOLD_RELOAD = HC_W'(HOLD_CYCLES - 1);
    localparam logic [ERR_W-1:0] ERR_MAX    = {ERR_W{1'b1}};
    localparam logic [ERR_W-1:0] ERR_ZERO   = {ERR_W{1'b0}};

    state_t          state_r;
    logic [HC_W-1:0] hold_cnt_r;
    logic [8:0]      expected_s;
    logic [8:0]      mask_s;
    logic            mismatch_s;
    logic [ERR_W-1:0] err_next_s;

    // vec_idx always equals {S,I0,I1}, so it keys the expected vector directly.
    mux_expected_gen u_exp (
        .idx      (vec_idx),
        .expected (expected_s)
    );

    // Mismatch mask and the saturating next error count for the current vector.
    always_comb begin
        mask_s     = mux_out ^ expected_s;
        mismatch_s = |mask_s;
        if (mismatch_s && (err_count != ERR_MAX)) begin
            err_next_s = err_count + {{(ERR_W-1){1'b0}}, 1'b1};
        end else begin
            err_next_s = err_count;
        end
    end

    // Sequencer FSM with registered stimulus and result outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r         <= ST_IDLE;
            hold_cnt_r      <= {HC_W{1'b0}};
            S               <= 1'b0;
            I0              <= 1'b0;
            I1              <= 1'b0;
            busy            <= 1'b0;
            done            <= 1'b0;
            pass            <= 1'b0;
            err_count       <= ERR_ZERO;
            vec_idx         <= 3'd0;
            first_fail_idx  <= 3'd0;
            first_fail_mask <= 9'd0;
        end else begin
            case (state_r)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        vec_idx         <= 3'd0;
                        {S, I0, I1}     <= 3'd0;
                        err_count       <= ERR_ZERO;
                        first_fail_idx  <= 3'd0;
                        first_fail_mask <= 9'd0;
                        done            <= 1'b0;
                        pass            <= 1'b0;
                        hold_cnt_r      <= HOLD_RELOAD;
                        busy            <= 1'b1;
                        state_r         <= ST_SETTLE;
                    end
                end
                ST_SETTLE: begin
                    if (hold_cnt_r != {HC_W{1'b0}}) begin
                        hold_cnt_r <= hold_cnt_r - {{(HC_W-1){1'b0}}, 1'b1};
                    end else begin
                        state_r <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    err_count <= err_next_s;
                    // A zero count means no mismatch has been seen yet this run.
                    if (mismatch_s && (err_count == ERR_ZERO)) begin
                        first_fail_idx  <= vec_idx;
                        first_fail_mask <= mask_s;
                    end
                    if (vec_idx == 3'd7) begin
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        pass    <= (err_next_s == ERR_ZERO);
                        state_r <= ST_DONE;
                    end else begin
                        vec_idx     <= vec_idx + 3'd1;
                        {S, I0, I1} <= vec_idx + 3'd1;
                        hold_cnt_r  <= HOLD_RELOAD;
                        state_r     <= ST_SETTLE;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule
